// File: rtl/uart_rx_cmd_decoder_if.sv
// Byte-stream and TAP-side signal bundle for uart_rx_cmd_decoder.
// The slave modport is the decoder. The master modport is the surrounding logic,
// which is the UART receiver on one side and the TAP on the other.
interface uart_rx_cmd_decoder_if #(
  parameter int unsigned DEPTH = 8
);
  logic [7:0]               RX_DATA_I;
  logic                     RX_VALID_I;
  logic                     RX_ERR_I;
  logic                     READ_I;
  logic [7:0]               DATA_REC_O;
  logic                     RX_EMPTY_O;
  logic                     CMD_REC_O;
  logic [$clog2(DEPTH):0]   LEVEL_O;
  logic                     OVERFLOW_O;
  logic                     RX_ERR_O;

  modport slave (
    input  RX_DATA_I, RX_VALID_I, RX_ERR_I, READ_I,
    output DATA_REC_O, RX_EMPTY_O, CMD_REC_O, LEVEL_O, OVERFLOW_O, RX_ERR_O
  );

  modport master (
    output RX_DATA_I, RX_VALID_I, RX_ERR_I, READ_I,
    input  DATA_REC_O, RX_EMPTY_O, CMD_REC_O, LEVEL_O, OVERFLOW_O, RX_ERR_O
  );
endinterface

// File: rtl/uart_rx_cmd_decoder.sv
// Splits the UART byte stream into data and command entries using an escape byte.
// The decoded entries are queued in a first-word-fall-through FIFO.
// The FIFO head is presented to the DMI UART TAP.
module uart_rx_cmd_decoder #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  ESC_CHAR = 8'h1B
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  uart_rx_cmd_decoder_if.slave   rx_if
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    S_DATA = 1'b0,
    S_ESC  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic [8:0]    w_push_entry;
  logic          w_err;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [8:0]    r_mem [DEPTH];
  logic          r_ovf;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic [8:0]    w_head;

  // Decoder state register; a reset discards any pending escape.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_state <= S_DATA;
    else         r_state <= w_state_nxt;
  end

  // Classifies each strobed byte and produces the {cmd, byte} entry to push.
  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_err        = 1'b0;
    if (rx_if.RX_VALID_I) begin
      if (rx_if.RX_ERR_I) begin
        w_err       = 1'b1;
        w_state_nxt = S_DATA;
      end else begin
        unique case (r_state)
          S_DATA: begin
            if (rx_if.RX_DATA_I == ESC_CHAR) begin
              w_state_nxt = S_ESC;
            end else begin
              w_push       = 1'b1;
              w_push_entry = {1'b0, rx_if.RX_DATA_I};
            end
          end
          S_ESC: begin
            w_push       = 1'b1;
            w_push_entry = (rx_if.RX_DATA_I == ESC_CHAR) ? {1'b0, ESC_CHAR}
                                                          : {1'b1, rx_if.RX_DATA_I};
            w_state_nxt  = S_DATA;
          end
          default: w_state_nxt = S_DATA;
        endcase
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = rx_if.READ_I && !w_empty;
  // A pop on a full FIFO frees the slot that the same-cycle push will use.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  // FIFO pointers; they are one bit wider than the address so that full can be told apart from empty.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage; it is deliberately left unreset.
  always_ff @(posedge CLK_I) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= w_push_entry;
  end

  // Registered single-cycle event pulses.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      r_err <= w_err;
    end
  end

  // The head is driven from registers only, so the TAP's READ path stays loop-free.
  always_comb begin
    w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  end

  assign rx_if.DATA_REC_O = w_head[7:0];
  assign rx_if.CMD_REC_O  = w_head[8];
  assign rx_if.RX_EMPTY_O = w_empty;
  assign rx_if.LEVEL_O    = r_wptr - r_rptr;
  assign rx_if.OVERFLOW_O = r_ovf;
  assign rx_if.RX_ERR_O   = r_err;

endmodule

// File: doc/uart_rx_cmd_decoder.md
# uart_rx_cmd_decoder

- Sits between the UART byte receiver and the DMI UART TAP.
- Separates the incoming byte stream into data bytes and command bytes using an escape-character protocol.
- Buffers the classified bytes in a first-word-fall-through FIFO.
- Presents the FIFO head to the TAP as the `DATA_REC`/`RX_EMPTY`/`CMD_REC`/`READ` interface.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `ESC_CHAR`, 8'h1B — escape byte value.

Ports:
- `CLK_I`  in  1  system clock.
- `RST_NI`  in  1  reset; one clock, reset asynchronous and active-low.
- `RX_DATA_I`  in  8  byte from UART receiver.
- `RX_VALID_I`  in  1  one-cycle strobe; `RX_DATA_I` valid.
- `RX_ERR_I`  in  1  framing/parity error; qualified by `RX_VALID_I`.
- `READ_I`  in  1  pop FIFO head (TAP `READ_O`).
- `DATA_REC_O`  out  8  head byte; 0 when empty.
- `RX_EMPTY_O`  out  1  FIFO empty.
- `CMD_REC_O`  out  1  head entry is a command; 0 when empty.
- `LEVEL_O`  out  $clog2(DEPTH)+1  current fill level.
- `OVERFLOW_O`  out  1  one-cycle pulse; a decoded entry was dropped.
- `RX_ERR_O`  out  1  one-cycle pulse; an errored byte was discarded.

## Operation
- **Decoder FSM**, two states: `S_DATA` (reset state) and `S_ESC`. Acts only on cycles with `RX_VALID_I`=1.
  - `S_DATA`, byte==`ESC_CHAR` -> `S_ESC`; nothing pushed.
  - `S_DATA`, other byte -> push {cmd=0, byte}; stay in `S_DATA`.
  - `S_ESC`, byte==`ESC_CHAR` -> push {cmd=0, `ESC_CHAR`} (escaped literal); -> `S_DATA`.
  - `S_ESC`, other byte -> push {cmd=1, byte}; -> `S_DATA`.
  - Any state, `RX_ERR_I`=1 -> byte discarded, no push, -> `S_DATA`, `RX_ERR_O` pulses next cycle.
- **FIFO**
  - 9-bit entries {cmd, byte}; `DEPTH` entries.
  - Read/write pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·`DEPTH`.
  - Empty when the pointers are equal. Full when only the MSBs differ.
  - Head is combinational from storage at the read pointer, gated to 0 when empty.
  - Pop: `READ_I`=1 and not empty. `READ_I` while empty is ignored; no pointer change.
  - Push:
    - Accepted when not full, or when full and a pop occurs in the same cycle.
    - Otherwise the entry is dropped, `OVERFLOW_O` pulses, and the FSM still advances.
  - Simultaneous push and pop on a non-empty FIFO: level unchanged, both pointers advance.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted; level becomes 1.
  - `LEVEL_O` = write pointer − read pointer, modulo 2·`DEPTH`; range 0..`DEPTH`.

## Timing
- Reset (`RST_NI` low, asynchronous):
  - FSM returns to `S_DATA`; pointers go to 0.
  - `RX_EMPTY_O`=1, `DATA_REC_O`=0, `CMD_REC_O`=0, `LEVEL_O`=0, `OVERFLOW_O`=0, `RX_ERR_O`=0.
  - Storage contents are not reset.
- Reset deassertion is synchronised externally. A reset mid-escape discards the pending escape.
- Latency: `RX_VALID_I` at edge N with a pushing byte -> entry visible on the outputs (`RX_EMPTY_O`=0) after edge N, i.e. in cycle N+1.
- An escaped command needs two strobes. It is visible the cycle after the second strobe.
- Pop: `READ_I` sampled at edge M -> the next head, or empty, is presented after edge M.
- `READ_I` may be asserted every cycle for back-to-back reads.
- Outputs depend combinationally only on registers, never on `READ_I`. This keeps the TAP's combinational `READ_O` loop-free.
- `OVERFLOW_O` and `RX_ERR_O` are registered; each pulses for exactly one cycle per event.
- Throughput: one push and one pop per cycle.

## Test plan
- **Plain data:** strobe 0x41, 0x42 -> `RX_EMPTY_O`=0 one cycle after the first strobe. Head reads 0x41 with `CMD_REC_O`=0, then 0x42. After two pops `RX_EMPTY_O`=1, `DATA_REC_O`=0.
- **Command and literal escape:** strobe 0x1B, 0x31, 0x1B, 0x1B, 0x55 -> FIFO holds {1,0x31}, {0,0x1B}, {0,0x55}. `LEVEL_O` reaches 3.
- **Overflow:** with `DEPTH`=8, push 9 data bytes with no reads -> `LEVEL_O`=8. `OVERFLOW_O` pulses once, on the 9th byte. Head is still byte 1.
- **Full with simultaneous pop:** full FIFO, strobe 0x77 while `READ_I`=1 -> byte accepted, `LEVEL_O` stays 8, no overflow. After 7 more pops 0x77 is the head.
- **Error mid-escape:** strobe 0x1B, then a byte with `RX_ERR_I`=1, then 0x31 -> `RX_ERR_O` pulses once. 0x31 is stored as data (cmd=0).
- **Reset mid-operation:** 3 entries queued plus a pending `ESC_CHAR`, assert `RST_NI` low asynchronously -> all outputs reach reset values immediately. After release, strobe 0x31 -> stored as data.
